// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-atomic arbiter for the shared write port of the async FIFO (clk_w domain).
// Optional burst limit: define WARB_BURST_LIMIT_EN to end a grant after MAX_BURST accepted beats.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8,
  localparam int GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk_w,
  input  logic                        arst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_w_en,
  output logic [DATA_WIDTH-1:0]       fifo_w_data,
  output logic                        grant_valid,
  output logic [GW-1:0]               grant_id
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_id_reg, grant_id_next;
  logic [GW-1:0]   last_id_reg, last_id_next;
  logic            xfer;
  logic            owner_valid;
  logic            owner_last;
  logic            beat_accept;
  logic            burst_hit;
  logic            sel_found;
  logic [GW-1:0]   sel_id;
  logic [DATA_WIDTH-1:0] masked_data [N_REQ];

  assign xfer        = (state_reg == XFER);
  assign grant_valid = xfer;
  assign grant_id    = grant_id_reg;
  assign owner_valid = req_valid[grant_id_reg];
  assign owner_last  = req_last[grant_id_reg];
  assign fifo_w_en   = xfer & owner_valid & ~fifo_full;
  assign beat_accept = fifo_w_en;

  // Ready and data steering depend only on grant state and fifo_full, never on non-owner inputs.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
    assign req_ready[gi]   = xfer && (grant_id_reg == GW'(gi)) && !fifo_full;
    assign masked_data[gi] = (xfer && (grant_id_reg == GW'(gi))) ?
                             req_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_comb begin
    fifo_w_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      fifo_w_data = fifo_w_data | masked_data[i];
    end
  end

  // Circular scan starting just after the previous owner.
  always_comb begin
    int idx_int;
    logic [GW-1:0] idx;
    sel_found = 1'b0;
    sel_id    = '0;
    idx_int   = 0;
    idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx_int = (int'(last_id_reg) + k) % N_REQ;
      idx     = idx_int[GW-1:0];
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_id    = idx;
      end
    end
  end

`ifdef WARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] beat_cnt_reg, beat_cnt_next;

  assign burst_hit = beat_accept && (beat_cnt_reg == CW'(MAX_BURST - 1));

  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    if (beat_accept) begin
      if (owner_last || burst_hit) beat_cnt_next = '0;
      else                         beat_cnt_next = beat_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_w or posedge arst) begin
    if (arst) beat_cnt_reg <= '0;
    else      beat_cnt_reg <= beat_cnt_next;
  end
`else
  // Without the limit a grant is never cut short (MAX_BURST is always >= 1).
  assign burst_hit = (MAX_BURST < 1);
`endif

  always_comb begin
    state_next    = state_reg;
    grant_id_next = grant_id_reg;
    last_id_next  = last_id_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          grant_id_next = sel_id;
          state_next    = XFER;
        end
      end
      XFER: begin
        if (beat_accept && (owner_last || burst_hit)) begin
          state_next   = IDLE;
          last_id_next = grant_id_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_w or posedge arst) begin
    if (arst) begin
      state_reg    <= IDLE;
      grant_id_reg <= '0;
      last_id_reg  <= GW'(N_REQ - 1);
    end else begin
      state_reg    <= state_next;
      grant_id_reg <= grant_id_next;
      last_id_reg  <= last_id_next;
    end
  end

endmodule
